gate_sweep_ctrl: RTL
====================

Name: gate_sweep_ctrl

Overview:
Sequencer that exhaustively characterises a combinational gate block (inputs A/B/C style, single output Y). It drives every input vector in ascending order, waits a settle interval, samples Y, and assembles the measured truth table. It compares the measured table against a caller-supplied expected table and reports per-vector mismatches and pass/fail. It sits between a test/config master (start/abort handshake) and the combinational block under characterisation.

Parameters:
N_IN, 3, number of block inputs; vectors = 2**N_IN (V)
SETTLE, 1, cycles each vector is held before sampling; legal range 1..15

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; honoured only in IDLE
abort  input  1  cancel a sweep in progress
expected  input  V  expected Y per vector, bit i = vector i; latched on accepted start
y_in  input  1  output Y of the characterised block
stim_out  output  N_IN  vector driven to block inputs (bit 0 = LSB input)
busy  output  1  high from APPLY of vector 0 through SAMPLE of vector V-1
done  output  1  one-cycle pulse after the final sample
truth_table  output  V  measured Y, bit i = vector i
mismatch  output  V  truth_table XOR latched expected, per vector
pass  output  1  high when mismatch == 0 at completion

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, settle count=0, stim_out=0, busy=0, done=0, truth_table=0, mismatch=0, pass=0, expected latch=0. Reset takes effect mid-sweep with no completion and no done.
- All outputs are registered. stim_out equals idx in APPLY/SAMPLE and is 0 in IDLE/DONE.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: start=1 -> APPLY. On the same edge: idx=0, cnt=SETTLE-1, truth_table=0, mismatch=0, pass=0, expected latched.
- APPLY: holds for SETTLE cycles. cnt=0 -> SAMPLE; otherwise cnt decrements.
- SAMPLE (1 cycle): on the exit edge, truth_table[idx]=y_in and mismatch[idx]=y_in^exp[idx]. If idx==V-1 -> DONE; otherwise idx+1 -> APPLY with cnt reloaded. idx is N_IN bits wide and never wraps within a sweep.
- DONE (1 cycle): done=1, pass=(mismatch==0), then -> IDLE.
- Results and pass hold until the next accepted start or reset.
- Latency: start sampled at edge 0. Vector i sampled at the end of cycle (SETTLE+1)*(i+1). done is high in cycle V*(SETTLE+1)+1. Default case: 8 vectors, done in cycle 17, busy high in cycles 1..16.
- start while busy or in DONE: ignored, with no effect on idx or expected.
- abort in APPLY/SAMPLE: -> IDLE on the next edge. Partial truth_table/mismatch remain as captured, pass=0, done is not pulsed. abort has priority over a same-cycle SAMPLE capture, so that vector is not written.
- abort in IDLE/DONE: ignored. abort and start in the same IDLE cycle: start wins.
- y_in is sampled only in SAMPLE; its value in any other state is don't-care.

Test Plan:
- Block Y=A&B (A=stim bit2, B=bit1), expected=8'hC0, SETTLE=1 -> stim_out steps 0..7 every 2 cycles, truth_table=8'hC0, mismatch=0, pass=1, done pulse in cycle 17.
- Block Y constant 0 (all-gates AND network), expected=8'h01 -> truth_table=8'h00, mismatch=8'h01, pass=0.
- SETTLE=3, Y=C (bit0), expected=8'hAA -> each vector held 4 cycles, done in cycle 33, truth_table=8'hAA, pass=1.
- abort asserted during SAMPLE of vector 4 -> IDLE next cycle, truth_table bits 7..4 = 0, no done, pass=0, stim_out=0. Then a new start completes normally.
- start pulsed again at vector 2, with expected changed -> no restart, original expected used, done at cycle 17.
- rst_n dropped asynchronously mid-APPLY -> all outputs 0 immediately. After release, start runs a full sweep.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: exhaustive truth-table sweeper for a small combinational block.
// Drives every input vector in ascending order, holds each for SETTLE cycles,
// samples the block output once, and builds the measured truth table plus a
// per-vector mismatch map against an expected table latched at start.
module gate_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1,
  localparam int V     = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [V-1:0]    expected,
  input  logic            y_in,
  output logic [N_IN-1:0] stim_out,
  output logic            busy,
  output logic            done,
  output logic [V-1:0]    truth_table,
  output logic [V-1:0]    mismatch,
  output logic            pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_DONE
  } state_t;

  // Settle counter reload; counts SETTLE-1 down to 0, so APPLY lasts SETTLE cycles.
  localparam logic [3:0]      CNT_LOAD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(V - 1);
  localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);

  state_t          state, state_next;
  logic [N_IN-1:0] idx, idx_next;
  logic [3:0]      cnt, cnt_next;
  logic [V-1:0]    exp_q, exp_next;
  logic [V-1:0]    tt_next, mm_next;
  logic            pass_next;
  logic            busy_next, done_next;
  logic [N_IN-1:0] stim_next;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state <= state_next;
    end
  end

  // Next-state and next-value logic for the sweep datapath.
  always_comb begin
    // NOTE: every variable gets a default before the case statement; a path
    // that leaves one unassigned would otherwise infer a latch.
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    exp_next   = exp_q;
    tt_next    = truth_table;
    mm_next    = mismatch;
    pass_next  = pass;

    case (state)
      S_IDLE: begin
        // abort is meaningless here; a same-cycle start is simply accepted.
        if (start) begin
          state_next = S_APPLY;
          idx_next   = '0;
          cnt_next   = CNT_LOAD;
          tt_next    = '0;
          mm_next    = '0;
          pass_next  = 1'b0;
          exp_next   = expected;
        end
      end

      S_APPLY: begin
        if (abort) begin
          state_next = S_IDLE;
          pass_next  = 1'b0;
        end else if (cnt == 4'd0) begin
          state_next = S_SAMPLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end

      S_SAMPLE: begin
        // abort wins over the capture: the vector being sampled is left unwritten.
        if (abort) begin
          state_next = S_IDLE;
          pass_next  = 1'b0;
        end else begin
          tt_next[idx] = y_in;
          mm_next[idx] = y_in ^ exp_q[idx];
          if (idx == IDX_LAST) begin
            state_next = S_DONE;
            // pass is registered alongside done, so it uses the final map.
            pass_next  = (mm_next == '0);
          end else begin
            state_next = S_APPLY;
            idx_next   = idx + IDX_ONE;
            cnt_next   = CNT_LOAD;
          end
        end
      end

      S_DONE: begin
        // start here is ignored; results stay held in IDLE.
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_next = (state_next == S_APPLY) || (state_next == S_SAMPLE);
    done_next = (state_next == S_DONE);
    stim_next = busy_next ? idx_next : '0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      cnt         <= '0;
      exp_q       <= '0;
      truth_table <= '0;
      mismatch    <= '0;
      pass        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stim_out    <= '0;
    end else begin
      idx         <= idx_next;
      cnt         <= cnt_next;
      exp_q       <= exp_next;
      truth_table <= tt_next;
      mismatch    <= mm_next;
      pass        <= pass_next;
      busy        <= busy_next;
      done        <= done_next;
      stim_out    <= stim_next;
    end
  end

endmodule
